wb_ram_slave: RTL

- Wishbone classic single-port RAM slave. It is the responder for the pipeline's data-memory master port.
- Accepts 32-bit reads and writes with byte selects and inserts a programmable number of wait states.
- Signals a bus error for out-of-range or empty-select requests.
- Sits on the data bus behind the memory stage; also serves as the bench target for the memory stage.

---
 rtl/wb_ram_slave.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wb_ram_slave.sv
// Wishbone classic single-port RAM slave with programmable wait states.
// Out-of-window addresses and empty byte selects terminate with err instead of ack.
module wb_ram_slave #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o
);

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:2] addr_q;
    logic [31:0] dat_q;

    logic        req;
    logic        cur_we;
    logic [3:0]  cur_sel;
    logic [31:2] cur_addr;
    logic [31:0] cur_dat;
    logic        in_range, bad_req, fire;
    logic [ADDR_WIDTH-1:0] idx;

    logic        ack_d, err_d;
    logic [31:0] dat_d;

    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_addr_i[1:0]};

    assign req = wbs_cyc_i & wbs_stb_i;

    // With zero wait states the response is decided on the capture edge itself,
    // so in IDLE the live bus stands in for the not-yet-latched copy.
    always_comb begin
        cur_we   = we_q;
        cur_sel  = sel_q;
        cur_addr = addr_q;
        cur_dat  = dat_q;
        if (state == S_IDLE) begin
            cur_we   = wbs_we_i;
            cur_sel  = wbs_sel_i;
            cur_addr = wbs_addr_i[31:2];
            cur_dat  = wbs_dat_i;
        end
    end

    // The window is aligned to its size, so range check and index are plain bit fields.
    assign in_range = (cur_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign idx      = cur_addr[ADDR_WIDTH+1:2];
    assign bad_req  = !in_range || (cur_sel == 4'b0000);
    assign fire     = (next_state == S_RESP) && !rst_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (req) next_state = (WS == 4'd0) ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (!req)            next_state = S_IDLE;
                else if (cnt <= 4'd1) next_state = S_RESP;
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic, registered below so ack/err coincide with the RESP state
    always_comb begin
        ack_d = fire && !bad_req;
        err_d = fire && bad_req;
        dat_d = 32'h0;
        if (fire && !bad_req && !cur_we) dat_d = mem[idx];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= 32'h0;
        end else begin
            wbs_ack_o <= ack_d;
            wbs_err_o <= err_d;
            wbs_dat_o <= dat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= 4'd0;
        end else if (state == S_IDLE && req) begin
            cnt <= WS;
        end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && state == S_IDLE && req) begin
            we_q   <= wbs_we_i;
            sel_q  <= wbs_sel_i;
            addr_q <= wbs_addr_i[31:2];
            dat_q  <= wbs_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire && !bad_req && cur_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_sel[b]) mem[idx][8*b +: 8] <= cur_dat[8*b +: 8];
            end
        end
    end

endmodule
